// File: rtl/lc3b_pmem_responder_if.sv
// ============================================================================
// Module   : lc3b_pmem_responder_if
// Brief    : Cache-line physical-memory bus between an L1 cache and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lc3b_pmem_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         protocol_err;

    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp,
        input  protocol_err
    );

    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp,
        output protocol_err
    );
endinterface

`default_nettype wire

// File: rtl/lc3b_pmem_responder.sv
// ============================================================================
// Module   : lc3b_pmem_responder
// Brief    : Whole-line read/write responder with programmable response latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3b_pmem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    lc3b_pmem_responder_if.slave pmem
);

    localparam int         c_DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [7:0] c_LAT_M1 = 8'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    if ((LATENCY < 1) || (LATENCY > 255)) begin : g_latency_range
        $error("lc3b_pmem_responder: LATENCY must be within 1..255");
    end

    if ((DEPTH_LOG2 < 1) || (DEPTH_LOG2 > 12)) begin : g_depth_range
        $error("lc3b_pmem_responder: DEPTH_LOG2 must be within 1..12");
    end

    logic [127:0]          r_mem [c_DEPTH];

    logic [1:0]            r_state;
    logic [7:0]            r_count;
    logic                  r_op_write;
    logic [DEPTH_LOG2-1:0] r_index;
    logic [127:0]          r_wdata;
    logic [127:0]          r_rdata;
    logic                  r_resp;
    logic                  r_err;

    logic                  w_req;
    logic                  w_req_held;
    logic                  w_both;
    logic [DEPTH_LOG2-1:0] w_in_index;
    logic [DEPTH_LOG2-1:0] w_rd_index;
    logic [127:0]          w_rd_line;
    logic [7:0]            w_count_dec;
    logic                  w_mem_we;
    logic                  w_unused_addr;

    // Offset bits and any index bits above the array are don't-care (aliasing).
    if (DEPTH_LOG2 < 12) begin : g_alias_bits
        assign w_unused_addr = ^{pmem.pmem_address[15:DEPTH_LOG2+4], pmem.pmem_address[3:0]};
    end else begin : g_no_alias_bits
        assign w_unused_addr = ^pmem.pmem_address[3:0];
    end

    assign w_req       = pmem.pmem_read | pmem.pmem_write;
    assign w_both      = pmem.pmem_read & pmem.pmem_write;
    assign w_req_held  = r_op_write ? pmem.pmem_write : pmem.pmem_read;
    assign w_in_index  = pmem.pmem_address[DEPTH_LOG2+3:4];
    assign w_count_dec = r_count - 8'd1;

    // With LATENCY=1 the read is served straight out of IDLE, so the line is
    // addressed from the live bus instead of the latched index.
    assign w_rd_index  = (r_state == c_ST_IDLE) ? w_in_index : r_index;
    assign w_rd_line   = r_mem[w_rd_index];

    // Reset in the RESP cycle must drop the write.
    assign w_mem_we    = !reset && (r_state == c_ST_RESP) && r_op_write;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    // r_count holds the cycles still to wait; the edge that takes it to zero enters RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_count    <= 8'd0;
            r_op_write <= 1'b0;
            r_index    <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_resp     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req) begin
                        r_op_write <= pmem.pmem_write;
                        r_index    <= w_in_index;
                        r_wdata    <= pmem.pmem_wdata;
                        r_count    <= c_LAT_M1;
                        if (w_both) begin
                            r_err <= 1'b1;
                        end
                        if (c_LAT_M1 == 8'd0) begin
                            r_state <= c_ST_RESP;
                            r_resp  <= 1'b1;
                            if (!pmem.pmem_write) begin
                                r_rdata <= w_rd_line;
                            end
                        end else begin
                            r_state <= c_ST_BUSY;
                        end
                    end
                end
                c_ST_BUSY: begin
                    if (!w_req_held) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_count_dec == 8'd0) begin
                        r_state <= c_ST_RESP;
                        r_resp  <= 1'b1;
                        r_count <= w_count_dec;
                        if (!r_op_write) begin
                            r_rdata <= w_rd_line;
                        end
                    end else begin
                        r_count <= w_count_dec;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign pmem.pmem_rdata   = r_rdata;
    assign pmem.pmem_resp    = r_resp;
    assign pmem.protocol_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lc3b_pmem_responder.sv
// ============================================================================
// Module   : tb_lc3b_pmem_responder
// Brief    : Scoreboard bench for two responders (LATENCY=4/12-bit index, LATENCY=1/4-bit index).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3b_pmem_responder;

    localparam int c_LAT0 = 4;
    localparam int c_LAT1 = 1;
    localparam int c_DL0  = 12;
    localparam int c_DL1  = 4;

    typedef struct {
        int           d;
        int           cyc;
        logic [127:0] rdata;
        logic         err;
    } exp_t;

    logic         clk;
    logic [1:0]   rst;
    logic [1:0]   rd;
    logic [1:0]   wr;
    logic [15:0]  addr_d [2];
    logic [127:0] wd_d   [2];
    int           cyc;
    int           n_tests;
    int           n_fail;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [127:0] mem_m [int];
    int           free_c [2];
    logic [127:0] last_rd [2];
    logic         err_m [2];

    lc3b_pmem_responder_if if0 ();
    lc3b_pmem_responder_if if1 ();

    assign if0.pmem_read    = rd[0];
    assign if0.pmem_write   = wr[0];
    assign if0.pmem_address = addr_d[0];
    assign if0.pmem_wdata   = wd_d[0];
    assign if1.pmem_read    = rd[1];
    assign if1.pmem_write   = wr[1];
    assign if1.pmem_address = addr_d[1];
    assign if1.pmem_wdata   = wd_d[1];

    lc3b_pmem_responder #(.DEPTH_LOG2(c_DL0), .LATENCY(c_LAT0)) u_dut0 (
        .clk   (clk),
        .reset (rst[0]),
        .pmem  (if0.slave)
    );

    lc3b_pmem_responder #(.DEPTH_LOG2(c_DL1), .LATENCY(c_LAT1)) u_dut1 (
        .clk   (clk),
        .reset (rst[1]),
        .pmem  (if1.slave)
    );

    logic [1:0]   o_resp;
    logic [1:0]   o_err;
    logic [127:0] o_rdata [2];
    assign o_resp[0]  = if0.pmem_resp;
    assign o_resp[1]  = if1.pmem_resp;
    assign o_err[0]   = if0.protocol_err;
    assign o_err[1]   = if1.protocol_err;
    assign o_rdata[0] = if0.pmem_rdata;
    assign o_rdata[1] = if1.pmem_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, req);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? c_LAT0 : c_LAT1;
    endfunction

    function automatic int line_of(input int d, input logic [15:0] a);
        int dl;
        dl = (d == 0) ? c_DL0 : c_DL1;
        return (int'(a) >> 4) & ((1 << dl) - 1);
    endfunction

    function automatic logic [127:0] mget(input int d, input int idx);
        int k;
        k = d * 65536 + idx;
        return mem_m.exists(k) ? mem_m[k] : 128'h0;
    endfunction

    // Monitor: each DUT response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (sb.size() > 0 && sb[0].d == d && sb[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_missing dut%0d: none by cycle %0d, required at cycle %0d", d, cyc, sb[0].cyc);
                sb.delete(0);
            end
            if (o_resp[d]) begin
                if (sb.size() == 0 || sb[0].d != d) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp_unexpected dut%0d: resp=1 at cycle %0d, required 0", d, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("resp_cycle dut%0d", d), 128'(cyc), 128'(mon_e.cyc));
                    chk($sformatf("resp_rdata dut%0d", d), o_rdata[d], mon_e.rdata);
                    chk($sformatf("resp_err dut%0d", d), 128'(o_err[d]), 128'(mon_e.err));
                end
            end
        end
    end

    task automatic wait_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        rd[d]  = 1'b0;
        wr[d]  = 1'b0;
        wait_cycle(cyc + 2);
        rst[d]     = 1'b0;
        free_c[d]  = cyc;
        last_rd[d] = 128'h0;
        err_m[d]   = 1'b0;
        chk($sformatf("reset_resp dut%0d", d), 128'(o_resp[d]), 128'h0);
        chk($sformatf("reset_rdata dut%0d", d), o_rdata[d], 128'h0);
        chk($sformatf("reset_err dut%0d", d), 128'(o_err[d]), 128'h0);
    endtask

    // Issues one request. Returns in the cycle after the response with the
    // request still raised (caller releases or chains), or, for an abort,
    // in the first cycle the responder is idle again.
    task automatic txn(input int d, input bit w, input bit r, input logic [15:0] a,
                       input logic [127:0] wd, input int abort_k, input bit rst_in_resp);
        int   acc;
        int   lat;
        int   idx;
        exp_t e;
        lat = lat_of(d);
        idx = line_of(d, a);
        acc = (cyc > free_c[d]) ? cyc : free_c[d];
        rd[d]     = r;
        wr[d]     = w;
        addr_d[d] = a;
        wd_d[d]   = wd;
        if (abort_k >= 0) begin
            wait_cycle(acc + 1 + abort_k);
            rd[d] = 1'b0;
            wr[d] = 1'b0;
            wait_cycle(acc + 2 + abort_k);
            free_c[d] = acc + 2 + abort_k;
            chk($sformatf("abort_rdata dut%0d", d), o_rdata[d], last_rd[d]);
        end else begin
            e.d   = d;
            e.cyc = acc + lat;
            if (w) begin
                e.rdata = last_rd[d];
            end else begin
                e.rdata    = mget(d, idx);
                last_rd[d] = e.rdata;
            end
            if (w && r) err_m[d] = 1'b1;
            e.err = err_m[d];
            sb.push_back(e);
            wait_cycle(acc + 1);
            addr_d[d] = 16'($urandom);
            wd_d[d]   = {$urandom, $urandom, $urandom, $urandom};
            if (rst_in_resp) begin
                wait_cycle(acc + lat);
                rst[d] = 1'b1;
                rd[d]  = 1'b0;
                wr[d]  = 1'b0;
                wait_cycle(acc + lat + 1);
                chk($sformatf("rst_in_resp_resp dut%0d", d), 128'(o_resp[d]), 128'h0);
                rst[d]     = 1'b0;
                free_c[d]  = acc + lat + 1;
                last_rd[d] = 128'h0;
                err_m[d]   = 1'b0;
            end else begin
                if (w) mem_m[d * 65536 + idx] = wd;
                free_c[d] = acc + lat + 2;
                wait_cycle(acc + lat + 1);
            end
        end
    endtask

    task automatic release_req(input int d);
        int t;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        t = cyc + int'($urandom_range(0, 2));
        wait_cycle(t);
    endtask

    task automatic rand_traffic(input int d, input int n);
        bit          w;
        int          k;
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            w = 1'($urandom_range(0, 1));
            a = {(d == 0) ? 8'h12 : 8'($urandom), 4'($urandom_range(0, 3)), 4'($urandom)};
            k = -1;
            if (lat_of(d) > 1 && $urandom_range(0, 4) == 0) k = int'($urandom_range(0, lat_of(d) - 2));
            txn(d, w, !w, a, {$urandom, $urandom, $urandom, $urandom}, k, 1'b0);
            if ($urandom_range(0, 1) == 1) release_req(d);
        end
        release_req(d);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 2'b11;
        rd      = 2'b00;
        wr      = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr_d[d]  = 16'h0;
            wd_d[d]    = 128'h0;
            free_c[d]  = 0;
            last_rd[d] = 128'h0;
            err_m[d]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        do_reset(0);
        do_reset(1);

        // Fresh line reads as zero.
        txn(0, 1'b0, 1'b1, 16'h0010, 128'h0, -1, 1'b0);
        release_req(0);

        // Write then chained read with a different offset in the same line.
        txn(0, 1'b1, 1'b0, 16'h1230, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, -1, 1'b0);
        txn(0, 1'b0, 1'b1, 16'h123E, 128'h0, -1, 1'b0);
        release_req(0);

        // Read aborted after two BUSY cycles, next request accepted right away.
        txn(0, 1'b0, 1'b1, 16'h0010, 128'h0, 2, 1'b0);
        txn(0, 1'b0, 1'b1, 16'h1234, 128'h0, -1, 1'b0);
        release_req(0);

        // Aborted write leaves the old contents.
        txn(0, 1'b1, 1'b0, 16'h0050, 128'hA5A5_0000_0000_0000_0000_0000_0000_0001, -1, 1'b0);
        release_req(0);
        txn(0, 1'b1, 1'b0, 16'h0058, 128'hFFFF_0000_0000_0000_0000_0000_0000_0002, 1, 1'b0);
        txn(0, 1'b0, 1'b1, 16'h0050, 128'h0, -1, 1'b0);
        release_req(0);

        // Read and write together: serviced as a write, error stays set.
        txn(0, 1'b1, 1'b1, 16'h0060, 128'hC0DE_C0DE_0000_0000_0000_0000_1234_5678, -1, 1'b0);
        release_req(0);
        txn(0, 1'b0, 1'b1, 16'h0060, 128'h0, -1, 1'b0);
        txn(0, 1'b0, 1'b1, 16'h1230, 128'h0, -1, 1'b0);
        release_req(0);
        do_reset(0);

        // Reset in the RESP cycle of a write drops it; array survives reset.
        txn(0, 1'b1, 1'b0, 16'h0070, 128'h7777_0000_0000_0000_0000_0000_0000_7777, -1, 1'b1);
        txn(0, 1'b0, 1'b1, 16'h0070, 128'h0, -1, 1'b0);
        release_req(0);
        txn(0, 1'b0, 1'b1, 16'h1230, 128'h0, -1, 1'b0);
        release_req(0);

        rand_traffic(0, 24);

        // LATENCY=1 and a 16-line array: back-to-back and aliased traffic.
        txn(1, 1'b1, 1'b0, 16'h0020, 128'h1111_2222_3333_4444_5555_6666_7777_8888, -1, 1'b0);
        txn(1, 1'b0, 1'b1, 16'hF125, 128'h0, -1, 1'b0);
        release_req(1);
        rand_traffic(1, 40);

        wait_cycle(cyc + 4);
        chk("scoreboard_drained", 128'(sb.size()), 128'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
